fifo_out_arbiter: RTL

Round-robin scheduler that shares one byte-serial output transmitter (start/finish handshake) among N_CH first-word-fall-through FIFOs. Each transfer pops one byte from the granted FIFO, presents it to the transmitter, waits for completion, then rotates priority. Sits between the per-source FIFOs and the single output driver. It replaces per-channel drain logic when several producers feed one output.

---
 rtl/fifo_out_pkg.sv | 28 ++
 rtl/fifo_out_arbiter_rr_pick.sv | 45 ++++
 rtl/fifo_out_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/fifo_out_pkg.sv
// ----------------------------------------------------------------------------
// fifo_out_pkg
// Shared definitions for the FIFO output arbiter:
//   - state_e   : 2-bit encoded arbiter FSM states
//   - *_DEF     : default channel count, data width and counter width
//   - onehot_of : builds a one-hot mask of a given width from an index
// ----------------------------------------------------------------------------
package fifo_out_pkg;

    localparam int N_CH_DEF  = 4;
    localparam int DW_DEF    = 8;
    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        POP     = 2'd1,
        SEND    = 2'd2,
        RELEASE = 2'd3
    } state_e;

    // One-hot mask with bit `idx` set, limited to 32 channels.
    function automatic logic [31:0] onehot_of(input int idx);
        logic [31:0] one_v;
        one_v = 32'd1;
        return one_v << idx;
    endfunction

endpackage

// File: rtl/fifo_out_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Searches the eligible mask starting at
// last_i+1 and wrapping modulo N_CH; the channel at last_i is visited last,
// so the previously served channel has lowest priority.
// Ports:
//   elig_i  [N_CH-1:0] : eligible channel mask
//   last_i  [LW-1:0]   : index of the last served channel
//   found_o            : at least one channel is eligible
//   pick_o  [N_CH-1:0] : one-hot selected channel (zero when none found)
// ----------------------------------------------------------------------------
module rr_pick
    import fifo_out_pkg::*;
#(
    parameter int N_CH = N_CH_DEF,
    parameter int LW   = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] elig_i,
    input  logic [LW-1:0]   last_i,
    output logic            found_o,
    output logic [N_CH-1:0] pick_o
);

    int              idx_s;
    logic [N_CH-1:0] cand_s;

    // Rotating first-eligible search; the first hit latches and later hits are ignored.
    always_comb begin
        found_o = 1'b0;
        pick_o  = '0;
        idx_s   = 0;
        cand_s  = '0;
        for (int off = 1; off <= N_CH; off++) begin
            idx_s  = (int'(last_i) + off) % N_CH;
            cand_s = N_CH'(onehot_of(idx_s));
            if (!found_o && ((elig_i & cand_s) != '0)) begin
                found_o = 1'b1;
                pick_o  = cand_s;
            end else begin
                found_o = found_o;
            end
        end
    end

endmodule

// File: rtl/fifo_out_arbiter.sv
// ----------------------------------------------------------------------------
// fifo_out_arbiter
// Round-robin scheduler sharing one byte-serial transmitter among N_CH
// first-word-fall-through FIFOs. Each transfer pops one word from the granted
// FIFO, holds it on out_data, requests transmission with out_start, waits for
// the out_finish level to rise and fall, then rotates priority.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   enable                  : permits new arbitration (in-flight transfers finish)
//   fifo_empty [N_CH]       : per-channel empty flag
//   fifo_busy  [N_CH]       : per-channel busy flag (busy channels are skipped)
//   fifo_data  [N_CH*DW]    : per-channel head word, channel i at [i*DW +: DW]
//   fifo_re    [N_CH]       : one-cycle pop strobe
//   out_data   [DW]         : word being transmitted
//   out_start               : transmit request, held until out_finish seen
//   out_finish              : transmitter completion level
//   grant      [N_CH]       : one-hot owner of the current transfer
//   busy                    : high whenever the FSM is not IDLE
//   done                    : one-cycle pulse per completed transfer
//   xfer_count [CNT_W]      : completed transfers, wraps silently
// All outputs come straight from flops.
// ----------------------------------------------------------------------------
module fifo_out_arbiter
    import fifo_out_pkg::*;
#(
    parameter int N_CH  = N_CH_DEF,
    parameter int DW    = DW_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [N_CH-1:0]    fifo_empty,
    input  logic [N_CH-1:0]    fifo_busy,
    input  logic [N_CH*DW-1:0] fifo_data,
    output logic [N_CH-1:0]    fifo_re,
    output logic [DW-1:0]      out_data,
    output logic               out_start,
    input  logic               out_finish,
    output logic [N_CH-1:0]    grant,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   xfer_count
);

    localparam int LW = $clog2(N_CH);

    state_e          state_q;
    logic [N_CH-1:0] fifo_re_q;
    logic [DW-1:0]   out_data_q;
    logic            out_start_q;
    logic [N_CH-1:0] grant_q;
    logic            busy_q;
    logic            done_q;
    logic [CNT_W-1:0] xfer_count_q;
    logic [LW-1:0]   last_q;
    logic [LW-1:0]   gidx_q;

    logic [N_CH-1:0] elig_s;
    logic            found_s;
    logic [N_CH-1:0] pick_s;
    logic [LW-1:0]   pick_idx_s;
    logic [DW-1:0]   data_sel_s;

    assign elig_s = ~fifo_empty & ~fifo_busy;

    rr_pick #(
        .N_CH (N_CH),
        .LW   (LW)
    ) u_rr_pick (
        .elig_i  (elig_s),
        .last_i  (last_q),
        .found_o (found_s),
        .pick_o  (pick_s)
    );

    // Convert the one-hot pick into an index and select that channel's head word.
    always_comb begin
        pick_idx_s = '0;
        data_sel_s = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (pick_s[i]) begin
                pick_idx_s = LW'(i);
                data_sel_s = fifo_data[i*DW +: DW];
            end else begin
                pick_idx_s = pick_idx_s;
            end
        end
    end

    // Arbiter FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            fifo_re_q    <= '0;
            out_data_q   <= '0;
            out_start_q  <= 1'b0;
            grant_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            xfer_count_q <= '0;
            last_q       <= LW'(N_CH - 1);
            gidx_q       <= '0;
        end else begin
            // Strobes default low so they last exactly one cycle.
            fifo_re_q <= '0;
            done_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (enable && found_s) begin
                        fifo_re_q  <= pick_s;
                        grant_q    <= pick_s;
                        out_data_q <= data_sel_s;
                        gidx_q     <= pick_idx_s;
                        busy_q     <= 1'b1;
                        state_q    <= POP;
                    end else begin
                        state_q    <= IDLE;
                    end
                end
                POP: begin
                    out_start_q <= 1'b1;
                    state_q     <= SEND;
                end
                SEND: begin
                    if (out_finish) begin
                        out_start_q <= 1'b0;
                        state_q     <= RELEASE;
                    end else begin
                        state_q     <= SEND;
                    end
                end
                RELEASE: begin
                    // Wait for the transmitter to drop its completion level
                    // so one finish pulse is never counted twice.
                    if (!out_finish) begin
                        done_q       <= 1'b1;
                        xfer_count_q <= xfer_count_q + CNT_W'(1);
                        last_q       <= gidx_q;
                        grant_q      <= '0;
                        busy_q       <= 1'b0;
                        state_q      <= IDLE;
                    end else begin
                        state_q      <= RELEASE;
                    end
                end
                default: begin
                    out_start_q <= 1'b0;
                    grant_q     <= '0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign fifo_re    = fifo_re_q;
    assign out_data   = out_data_q;
    assign out_start  = out_start_q;
    assign grant      = grant_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign xfer_count = xfer_count_q;

endmodule
